// File: rtl/bit_population_pattern_gen.sv
// bit_population_pattern_gen
// Streams every WIDTH-bit word with exactly k bits set, in ascending order,
// over a valid/ready interface. The final word of a command carries data_last_o.
// A request with k > WIDTH is rejected with a one-cycle err_o pulse.
module bit_population_pattern_gen #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [CW-1:0]    count_i,
  input  logic             cmd_val_i,
  output logic             cmd_rdy_o,
  output logic [WIDTH-1:0] data_o,
  output logic             data_val_o,
  input  logic             data_rdy_i,
  output logic             data_last_o,
  output logic             err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] top_reg, top_next;
  logic             val_reg, val_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] first_pat;
  logic [WIDTH-1:0] top_pat;
  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] ripple;
  logic [WIDTH-1:0] next_pat;
  logic [CW-1:0]    ctz;
  logic [CW:0]      shamt;
  logic             last;

  // k ones in the LSBs is the smallest word of the set; k ones in the MSBs is
  // the largest. Shifting an all-ones word by k covers k = 0 and k = WIDTH.
  assign first_pat = ~({WIDTH{1'b1}} << count_i);
  assign top_pat   = ~({WIDTH{1'b1}} >> count_i);

  // Trailing-zero count of the current word, lowest set bit wins.
  always_comb begin
    ctz = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_reg[i]) ctz = CW'(i);
    end
  end

  // Next word with the same population (Gosper's hack). Only consumed for
  // non-last words, so the add never carries out of WIDTH bits, and the
  // divide by the lowest set bit is replaced by a shift of ctz + 2.
  assign low_bit  = data_reg & (-data_reg);
  assign ripple   = data_reg + low_bit;
  assign shamt    = {1'b0, ctz} + (CW + 1)'(2);
  assign next_pat = ripple | ((ripple ^ data_reg) >> shamt);

  assign last = val_reg & (data_reg == top_reg);

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    top_next   = top_reg;
    val_next   = val_reg;
    err_next   = 1'b0;
    if (state_reg == IDLE) begin
      if (cmd_val_i) begin
        if (count_i > CW'(WIDTH)) begin
          err_next = 1'b1;
        end else begin
          data_next  = first_pat;
          top_next   = top_pat;
          val_next   = 1'b1;
          state_next = RUN;
        end
      end
    end else begin
      if (val_reg && data_rdy_i) begin
        if (last) begin
          val_next   = 1'b0;
          state_next = IDLE;
        end else begin
          data_next = next_pat;
        end
      end
    end
  end

  // State and output registers; reset discards any sequence in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      top_reg   <= '0;
      val_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      top_reg   <= top_next;
      val_reg   <= val_next;
      err_reg   <= err_next;
    end
  end

  assign cmd_rdy_o   = (state_reg == IDLE);
  assign data_o      = data_reg;
  assign data_val_o  = val_reg;
  assign data_last_o = last;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_bit_population_pattern_gen.sv
// Testbench for bit_population_pattern_gen: a WIDTH=4 instance checked against
// a queue of hand-computed words, and a WIDTH=16 instance streaming k=8
// under random backpressure with per-word property checks.
module tb_bit_population_pattern_gen;

  localparam int W4   = 4;
  localparam int CW4  = 3;
  localparam int W16  = 16;
  localparam int CW16 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [CW4-1:0] count4;
  logic           cmd_val4, cmd_rdy4;
  logic [W4-1:0]  data4;
  logic           val4, rdy4, last4, err4;

  logic [CW16-1:0] count16;
  logic            cmd_val16, cmd_rdy16;
  logic [W16-1:0]  data16;
  logic            val16, rdy16, last16, err16;

  bit_population_pattern_gen #(.WIDTH(W4)) dut4 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .count_i    (count4),
    .cmd_val_i  (cmd_val4),
    .cmd_rdy_o  (cmd_rdy4),
    .data_o     (data4),
    .data_val_o (val4),
    .data_rdy_i (rdy4),
    .data_last_o(last4),
    .err_o      (err4)
  );

  bit_population_pattern_gen #(.WIDTH(W16)) dut16 (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .count_i    (count16),
    .cmd_val_i  (cmd_val16),
    .cmd_rdy_o  (cmd_rdy16),
    .data_o     (data16),
    .data_val_o (val16),
    .data_rdy_i (rdy16),
    .data_last_o(last16),
    .err_o      (err16)
  );

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic          last;
    logic [W4-1:0] data;
  } exp_t;

  exp_t q4[$];
  int   xfer4 = 0;

  int             xfer16 = 0;
  logic [W16-1:0] prev16 = '0;
  logic           done16 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push4(input logic [W4-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q4.push_back(e);
  endtask

  task automatic issue4(input int k);
    count4   = CW4'(k);
    cmd_val4 = 1'b1;
    @(posedge clk);
    #1 cmd_val4 = 1'b0;
  endtask

  task automatic drain4(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (q4.size() == 0) break;
      @(negedge clk);
    end
    #1 chk("drain4_queue_empty", 32'(q4.size()), 32'd0);
  endtask

  // Monitor for the WIDTH=4 instance: pops the scoreboard on each transfer.
  initial begin
    logic          stall;
    logic [W4-1:0] hold_data;
    exp_t          e;
    stall = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold4_val", 32'(val4), 32'd1);
          chk("hold4_data", 32'(data4), 32'(hold_data));
        end
        if (val4 && rdy4) begin
          if (q4.size() == 0) begin
            checks++;
            $display("FAIL unexpected4: got word %b last %b, expected no word", data4, last4);
          end else begin
            e = q4.pop_front();
            $display("w4 xfer data=%b last=%b", data4, last4);
            chk("data4", 32'(data4), 32'(e.data));
            chk("last4", 32'(last4), 32'(e.last));
          end
          xfer4++;
        end
        stall = val4 && !rdy4;
        hold_data = data4;
      end
    end
  end

  // Monitor for the WIDTH=16 instance: popcount, ordering, last tagging, stalls.
  initial begin
    logic           stall;
    logic [W16-1:0] hold_data;
    stall = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold16_val", 32'(val16), 32'd1);
          chk("hold16_data", 32'(data16), 32'(hold_data));
        end
        if (val16 && rdy16) begin
          chk("pop16", 32'($countones(data16)), 32'd8);
          if (xfer16 > 0) chk("ascending16", 32'(data16 > prev16), 32'd1);
          chk("last16", 32'(last16), 32'(data16 == 16'hFF00));
          prev16 = data16;
          xfer16++;
          if (last16) begin
            done16 = 1'b1;
            $display("w16 last xfer #%0d data=%h", xfer16, data16);
          end
        end
        stall = val16 && !rdy16;
        hold_data = data16;
      end
    end
  end

  initial begin
    int accepts;
    int target;
    bit ok;

    rst_n     = 1'b1;
    count4    = '0;
    cmd_val4  = 1'b0;
    rdy4      = 1'b1;
    count16   = '0;
    cmd_val16 = 1'b0;
    rdy16     = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data4", 32'(data4), 32'd0);
    chk("rst_val4", 32'(val4), 32'd0);
    chk("rst_last4", 32'(last4), 32'd0);
    chk("rst_err4", 32'(err4), 32'd0);
    chk("rst_cmd_rdy4", 32'(cmd_rdy4), 32'd1);
    chk("rst_val16", 32'(val16), 32'd0);
    chk("rst_cmd_rdy16", 32'(cmd_rdy16), 32'd1);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // k=2, continuous ready: six words on consecutive cycles
    push4(4'b0011, 1'b0);
    push4(4'b0101, 1'b0);
    push4(4'b0110, 1'b0);
    push4(4'b1001, 1'b0);
    push4(4'b1010, 1'b0);
    push4(4'b1100, 1'b1);
    issue4(2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("k2_val_consecutive", 32'(val4), 32'd1);
    end
    @(negedge clk);
    chk("k2_val_after_last", 32'(val4), 32'd0);
    chk("k2_cmd_rdy_after_last", 32'(cmd_rdy4), 32'd1);
    chk("k2_queue_empty", 32'(q4.size()), 32'd0);
    @(posedge clk);
    #1;

    // k=0 and k=4: single word each, one cycle after accept
    push4(4'b0000, 1'b1);
    issue4(0);
    @(negedge clk);
    chk("k0_val_latency", 32'(val4), 32'd1);
    @(negedge clk);
    chk("k0_val_done", 32'(val4), 32'd0);
    chk("k0_cmd_rdy", 32'(cmd_rdy4), 32'd1);
    @(posedge clk);
    #1;
    push4(4'b1111, 1'b1);
    issue4(4);
    @(negedge clk);
    chk("k4_val_latency", 32'(val4), 32'd1);
    @(negedge clk);
    chk("k4_val_done", 32'(val4), 32'd0);
    chk("k4_cmd_rdy", 32'(cmd_rdy4), 32'd1);
    @(posedge clk);
    #1;

    // k=5 > WIDTH: one-cycle error pulse, no data
    issue4(5);
    @(negedge clk);
    chk("k5_err_pulse", 32'(err4), 32'd1);
    chk("k5_val", 32'(val4), 32'd0);
    chk("k5_cmd_rdy", 32'(cmd_rdy4), 32'd1);
    @(negedge clk);
    chk("k5_err_cleared", 32'(err4), 32'd0);
    chk("k5_val_after", 32'(val4), 32'd0);
    chk("k5_cmd_rdy_after", 32'(cmd_rdy4), 32'd1);
    @(posedge clk);
    #1;

    // k=1, asynchronous reset after the second transfer
    push4(4'b0001, 1'b0);
    push4(4'b0010, 1'b0);
    target = xfer4 + 2;
    issue4(1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (xfer4 >= target) begin
        ok = 1'b1;
        break;
      end
    end
    chk("k1_two_xfers_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(data4), 32'd0);
    chk("async_rst_val", 32'(val4), 32'd0);
    chk("async_rst_last", 32'(last4), 32'd0);
    chk("async_rst_cmd_rdy", 32'(cmd_rdy4), 32'd1);
    #12 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle_val", 32'(val4), 32'd0);
    end
    chk("post_rst_queue_empty", 32'(q4.size()), 32'd0);
    @(posedge clk);
    #1;
    push4(4'b0111, 1'b0);
    push4(4'b1011, 1'b0);
    push4(4'b1101, 1'b0);
    push4(4'b1110, 1'b1);
    issue4(3);
    drain4(20);
    @(posedge clk);
    #1;

    // cmd_val held through RUN: second command only after the first ends
    for (int r = 0; r < 2; r++) begin
      push4(4'b0011, 1'b0);
      push4(4'b0101, 1'b0);
      push4(4'b0110, 1'b0);
      push4(4'b1001, 1'b0);
      push4(4'b1010, 1'b0);
      push4(4'b1100, 1'b1);
    end
    count4   = 3'd2;
    cmd_val4 = 1'b1;
    accepts  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmd_rdy4) accepts++;
      if (accepts == 2) break;
    end
    chk("hold_cmd_two_accepts", 32'(accepts), 32'd2);
    @(posedge clk);
    #1 cmd_val4 = 1'b0;
    drain4(30);
    @(negedge clk);
    chk("hold_cmd_idle_after", 32'(val4), 32'd0);
    @(posedge clk);
    #1;

    // WIDTH=16, k=8 under random backpressure
    count16   = 5'd8;
    cmd_val16 = 1'b1;
    @(posedge clk);
    #1 cmd_val16 = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      if (done16) break;
      rdy16 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    rdy16 = 1'b0;
    chk("w16_done", 32'(done16), 32'd1);
    chk("w16_count", 32'(xfer16), 32'd12870);
    chk("w16_last_word", 32'(prev16), 32'hFF00);
    @(negedge clk);
    chk("w16_val_after", 32'(val16), 32'd0);
    chk("w16_cmd_rdy_after", 32'(cmd_rdy16), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
